// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory request/response port, the redirect input
// and the instruction output toward the datapath.
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Credit-limited instruction fetch unit: at most two words in flight or buffered,
// a 2-entry {pc, instr} buffer, and redirect handling that discards stale responses.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  logic        run_r;
  logic [63:0] fetch_pc_r;
  logic [1:0]  outstanding_r;
  logic [1:0]  discard_r;
  logic [1:0]  count_r;
  logic        head_r;
  logic        ipc_head_r;
  logic [63:0] ipc_q_r    [2];
  logic [63:0] fifo_pc_r  [2];
  logic [31:0] fifo_ins_r [2];

  logic [2:0]  credit_s;
  logic        req_s;
  logic        gnt_fire_s;
  logic        rv_ok_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  out_next_s;
  logic        ipc_wr_idx_s;
  logic        fifo_wr_idx_s;

  // Request gating, handshake qualification and buffer bookkeeping.
  always_comb begin
    credit_s      = {1'b0, outstanding_r} + {1'b0, count_r};
    req_s         = 1'b0;
    gnt_fire_s    = 1'b0;
    rv_ok_s       = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    ipc_wr_idx_s  = ipc_head_r ^ outstanding_r[0];
    fifo_wr_idx_s = head_r ^ count_r[0];
    if (run_r && !bus.redirect_valid && (credit_s < 3'd2)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    gnt_fire_s = req_s && bus.imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    rv_ok_s    = bus.imem_rvalid && (outstanding_r != 2'd0);
    out_next_s = outstanding_r + {1'b0, gnt_fire_s} - {1'b0, rv_ok_s};
    if (!bus.redirect_valid) begin
      push_s = rv_ok_s && (discard_r == 2'd0);
      pop_s  = (count_r != 2'd0) && bus.instr_ready;
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  assign bus.imem_req    = req_s;
  assign bus.imem_addr   = fetch_pc_r;
  assign bus.instr_valid = (count_r != 2'd0);
  assign bus.instr       = fifo_ins_r[head_r];
  assign bus.instr_pc    = fifo_pc_r[head_r];

  // Fetch PC, in-flight pc queue, discard counter and instruction buffer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r         <= 1'b0;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= 2'd0;
      discard_r     <= 2'd0;
      count_r       <= 2'd0;
      head_r        <= 1'b0;
      ipc_head_r    <= 1'b0;
      ipc_q_r[0]    <= 64'h0;
      ipc_q_r[1]    <= 64'h0;
      fifo_pc_r[0]  <= 64'h0;
      fifo_pc_r[1]  <= 64'h0;
      fifo_ins_r[0] <= 32'h0;
      fifo_ins_r[1] <= 32'h0;
    end else begin
      run_r         <= 1'b1;
      outstanding_r <= out_next_s;
      if (gnt_fire_s) begin
        ipc_q_r[ipc_wr_idx_s] <= fetch_pc_r;
      end else begin
        ipc_q_r[ipc_wr_idx_s] <= ipc_q_r[ipc_wr_idx_s];
      end
      if (rv_ok_s) begin
        ipc_head_r <= ~ipc_head_r;
      end else begin
        ipc_head_r <= ipc_head_r;
      end
      if (bus.redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc_r <= {bus.redirect_pc[63:2], 2'b00};
        discard_r  <= out_next_s;
        count_r    <= 2'd0;
        head_r     <= 1'b0;
      end else begin
        if (gnt_fire_s) begin
          fetch_pc_r <= fetch_pc_r + 64'd4;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (rv_ok_s && (discard_r != 2'd0)) begin
          discard_r <= discard_r - 2'd1;
        end else begin
          discard_r <= discard_r;
        end
        if (push_s) begin
          fifo_pc_r[fifo_wr_idx_s]  <= ipc_q_r[ipc_head_r];
          fifo_ins_r[fifo_wr_idx_s] <= bus.imem_rdata;
        end else begin
          fifo_pc_r[fifo_wr_idx_s]  <= fifo_pc_r[fifo_wr_idx_s];
          fifo_ins_r[fifo_wr_idx_s] <= fifo_ins_r[fifo_wr_idx_s];
        end
        if (pop_s) begin
          head_r <= ~head_r;
        end else begin
          head_r <= head_r;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + 2'd1;
          2'b01:   count_r <= count_r - 2'd1;
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change on the falling edge, outputs are
// checked 1 ns later against hand-computed values.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.instr_ready    = 1'b0;
  endtask

  // Returns on a falling edge with the unit out of reset and allowed to request.
  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();

    // Reset values
    #3;
    chk("rst_req",   {63'h0, bus.imem_req},    64'h0);
    chk("rst_addr",  bus.imem_addr,            64'h0);
    chk("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, bus.instr},       64'h0);
    chk("rst_pc",    bus.instr_pc,             64'h0);

    // Basic stream, gnt high, rvalid one cycle after gnt
    reset_dut();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; #1;
    chk("s1_c0_req",   {63'h0, bus.imem_req},    64'h1);
    chk("s1_c0_addr",  bus.imem_addr,            64'h0);
    chk("s1_c0_valid", {63'h0, bus.instr_valid}, 64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00C00293; #1;
    chk("s1_c1_req",   {63'h0, bus.imem_req},    64'h1);
    chk("s1_c1_addr",  bus.imem_addr,            64'h4);
    chk("s1_c1_valid", {63'h0, bus.instr_valid}, 64'h0);
    @(negedge clk);
    bus.imem_rdata = 32'h00500093; #1;
    chk("s1_c2_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("s1_c2_instr", {32'h0, bus.instr},       64'h00C00293);
    chk("s1_c2_pc",    bus.instr_pc,             64'h0);
    chk("s1_c2_req",   {63'h0, bus.imem_req},    64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s1_c3_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("s1_c3_instr", {32'h0, bus.instr},       64'h00500093);
    chk("s1_c3_pc",    bus.instr_pc,             64'h4);
    chk("s1_c3_req",   {63'h0, bus.imem_req},    64'h1);
    chk("s1_c3_addr",  bus.imem_addr,            64'h8);

    // Backpressure: two requests fill the buffer, then drain
    reset_dut();
    bus.imem_gnt = 1'b1; #1;
    chk("s2_c0_addr", bus.imem_addr, 64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA0A0_0000; #1;
    chk("s2_c1_addr", bus.imem_addr, 64'h4);
    @(negedge clk);
    bus.imem_rdata = 32'hA1A1_0004; #1;
    chk("s2_c2_req", {63'h0, bus.imem_req}, 64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s2_c3_req", {63'h0, bus.imem_req}, 64'h0);
    @(negedge clk); #1;
    chk("s2_c4_req",   {63'h0, bus.imem_req}, 64'h0);
    chk("s2_c4_addr",  bus.imem_addr,         64'h8);
    chk("s2_c4_instr", {32'h0, bus.instr},    64'hA0A0_0000);
    @(negedge clk);
    bus.instr_ready = 1'b1; #1;
    chk("s2_c5_pc",  bus.instr_pc,         64'h0);
    chk("s2_c5_req", {63'h0, bus.imem_req}, 64'h0);
    @(negedge clk); #1;
    chk("s2_c6_pc",    bus.instr_pc,         64'h4);
    chk("s2_c6_instr", {32'h0, bus.instr},    64'hA1A1_0004);
    chk("s2_c6_req",   {63'h0, bus.imem_req}, 64'h1);
    chk("s2_c6_addr",  bus.imem_addr,         64'h8);

    // Redirect with two outstanding; low address bits ignored
    reset_dut();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1;
    @(negedge clk); #1;
    chk("s3_c1_addr", bus.imem_addr, 64'h4);
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h103; #1;
    chk("s3_c2_req", {63'h0, bus.imem_req}, 64'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_0000; #1;
    chk("s3_c3_req",   {63'h0, bus.imem_req},    64'h0);
    chk("s3_c3_addr",  bus.imem_addr,            64'h100);
    chk("s3_c3_valid", {63'h0, bus.instr_valid}, 64'h0);
    @(negedge clk);
    bus.imem_rdata = 32'hDEAD_0004; #1;
    chk("s3_c4_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s3_c4_req",   {63'h0, bus.imem_req},    64'h1);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1; #1;
    chk("s3_c5_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s3_c5_addr",  bus.imem_addr,            64'h100);
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0011; #1;
    chk("s3_c6_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s3_c6_addr",  bus.imem_addr,            64'h104);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s3_c7_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("s3_c7_instr", {32'h0, bus.instr},       64'h11);
    chk("s3_c7_pc",    bus.instr_pc,             64'h100);

    // Redirect coinciding with rvalid and pop, one entry buffered
    reset_dut();
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hB0B0_0000;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rdata = 32'hB1B1_0004; bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h100; #1;
    chk("s4_c2_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("s4_c2_pc",    bus.instr_pc,             64'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1; #1;
    chk("s4_c3_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s4_c3_req",   {63'h0, bus.imem_req},    64'h1);
    chk("s4_c3_addr",  bus.imem_addr,            64'h100);
    @(negedge clk);
    bus.imem_gnt = 1'b0; #1;
    chk("s4_c4_valid", {63'h0, bus.instr_valid}, 64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_00C0; #1;
    chk("s4_c5_valid", {63'h0, bus.instr_valid}, 64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s4_c6_instr", {32'h0, bus.instr}, 64'hC0);
    chk("s4_c6_pc",    bus.instr_pc,       64'h100);

    // Grant withheld: request and address hold
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s5_hold_req",  {63'h0, bus.imem_req}, 64'h1);
      chk("s5_hold_addr", bus.imem_addr,         64'h0);
      @(negedge clk);
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; #1;
    chk("s5_after_addr", bus.imem_addr, 64'h4);

    // Asynchronous reset with a full buffer, then a stray response
    reset_dut();
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hE0E0_0000;
    @(negedge clk);
    bus.imem_rdata = 32'hE1E1_0004;
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s6_full_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("s6_full_req",   {63'h0, bus.imem_req},    64'h0);
    #1 rst_n = 1'b0; #1;
    chk("s6_rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s6_rst_req",   {63'h0, bus.imem_req},    64'h0);
    chk("s6_rst_addr",  bus.imem_addr,            64'h0);
    chk("s6_rst_instr", {32'h0, bus.instr},       64'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_00EE; bus.instr_ready = 1'b1; #1;
    chk("s6_rel_req",  {63'h0, bus.imem_req}, 64'h1);
    chk("s6_rel_addr", bus.imem_addr,         64'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; #1;
    chk("s6_stray_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("s6_stray_addr",  bus.imem_addr,            64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request valid.
REQ-005 imem_addr  output  64  fetch address; word aligned.
REQ-006 imem_gnt  input  1  request accepted this cycle.
REQ-007 imem_rvalid  input  1  response data valid; in request order, at least one cycle after its gnt.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from datapath.
REQ-010 redirect_pc  input  64  redirect target.
REQ-011 instr_valid  output  1  instr/instr_pc valid to datapath.
REQ-012 instr  output  32  instruction word.
REQ-013 instr_pc  output  64  address of instr.
REQ-014 instr_ready  input  1  datapath consumes when high with instr_valid.

Function
REQ-015 Internal fetch_pc register drives imem_addr; it increments by 4 on each cycle with imem_req && imem_gnt and wraps modulo 2^64.
REQ-016 The instruction buffer is a 2-entry FIFO of {pc, instr}. instr_valid = FIFO non-empty, and the outputs present the head entry combinationally from registers.
REQ-017 credit = outstanding + fifo_count. imem_req asserts only when credit < 2 and no redirect is presented this cycle, so the FIFO can never overflow.
REQ-018 imem_req and imem_addr hold stable while waiting for gnt, unless a redirect occurs.
REQ-019 Each granted request increments outstanding (max 2). Each imem_rvalid decrements it.
REQ-020 imem_rvalid with discard_cnt == 0 pushes {pc of oldest outstanding request, imem_rdata} into the FIFO. Entry pc values are tracked in a 2-entry in-flight pc queue.
REQ-021 instr_valid && instr_ready pops the head. Push and pop in the same cycle are both performed, and the count is unchanged.
REQ-022 Latency: rvalid at cycle N gives instr_valid at cycle N+1. On an empty, idle path: req/gnt at cycle 0 and rvalid at cycle 1 give instr_valid at cycle 2.
REQ-023 redirect_valid at cycle N has the following effects at the edge ending N:
  - FIFO is flushed.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - discard_cnt <= outstanding after this cycle's gnt/rvalid accounting, so rvalid at N is dropped and gnt at N is counted.
  - Pop at N is ignored.
REQ-024 imem_req is forced low in the redirect cycle. From N+1, requests use the new address.
REQ-025 While discard_cnt > 0, each rvalid is dropped and decrements both discard_cnt and outstanding.
REQ-026 A second redirect while discards are pending adds the newly outstanding requests to discard; no stale word ever reaches instr.
REQ-027 imem_rvalid with outstanding == 0 is a protocol violation. It is ignored, and no state changes.
REQ-028 redirect_pc[1:0] is ignored, and no exception is raised.

Reset
REQ-029 While rst_n is low, asynchronously:
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard_cnt = 0.
  - imem_req = 0; instr_valid = 0.
  - instr = 32'h0; instr_pc = 64'h0.
  - imem_addr = RESET_PC.
REQ-030 Reset asserted mid-transaction abandons all in-flight requests. Responses that arrive after rst_n rises are protocol violations per REQ-027.
REQ-031 imem_req may first assert in the first clk cycle after rst_n deasserts.

Verification
REQ-032 Reset with RESET_PC=0, gnt tied high, rvalid one cycle after gnt, rdata = 32'h00C00293 then 32'h00500093, instr_ready=1 -> instr_valid at cycle 2 with instr=32'h00C00293, instr_pc=0; next cycle instr=32'h00500093, instr_pc=4.
REQ-033 instr_ready=0 with continuous grants -> exactly 2 requests issued (addr 0, 4), FIFO full, imem_req low. Raise ready -> pc 0 then 4 delivered, then a request for addr 8.
REQ-034 Two requests outstanding (0, 4), then redirect_valid with redirect_pc=64'h100 -> both responses dropped, next imem_addr=64'h100, first delivered instr_pc=64'h100.
REQ-035 Redirect in the same cycle as an rvalid and a pop, with FIFO holding 1 entry -> FIFO empty next cycle, rvalid dropped, no instr_valid until a response for 64'h100 arrives.
REQ-036 gnt withheld for 5 cycles -> imem_req and imem_addr stable throughout.
REQ-037 rst_n pulsed low mid-stream with FIFO full -> instr_valid and imem_req drop immediately (asynchronously). After release, fetch restarts at RESET_PC.
